// File: rtl/accum_table_ctrl.sv
// rtl/accum_table_ctrl.sv - accumulator table sequencer for CLEAR, skewed WRITE and READ commands
// Optional perf counters are enabled by defining ACCUM_CTRL_PERF_EN.
module accum_table_ctrl #(
    parameter int MAX_OUT_ROWS = 128,
    parameter int MAX_OUT_COLS = 128,
    parameter int SYS_ARR_ROWS = 16,
    parameter int SYS_ARR_COLS = 16,
    localparam int NUM_ACCUM_ROWS = MAX_OUT_ROWS * (MAX_OUT_COLS / SYS_ARR_COLS),
    localparam int AW = $clog2(NUM_ACCUM_ROWS),
    localparam int NW = $clog2(MAX_OUT_ROWS) + 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic [1:0]                   op,
    input  logic [AW-1:0]                base_addr,
    input  logic [NW-1:0]                num_rows,
    output logic                         busy,
    output logic                         done,
    output logic                         rd_valid,
    output logic [SYS_ARR_COLS-1:0]      clear,
    output logic [SYS_ARR_COLS-1:0]      rd_en,
    output logic [SYS_ARR_COLS-1:0]      wr_en,
    output logic [AW*SYS_ARR_COLS-1:0]   rd_addr,
    output logic [AW*SYS_ARR_COLS-1:0]   wr_addr
`ifdef ACCUM_CTRL_PERF_EN
    ,
    output logic [31:0]                  perf_busy_cycles,
    output logic [15:0]                  perf_cmds
`endif
);

    localparam int TW = $clog2(MAX_OUT_ROWS + SYS_ARR_COLS + 0 * SYS_ARR_ROWS);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_WRITE, S_READ, S_FIN} state_t;

    state_t                      state_q, state_d;
    logic [TW-1:0]               t_q, t_d;
    logic [AW-1:0]               base_q, base_d;
    logic [NW-1:0]               n_q, n_d;

    logic                        busy_d, done_d, rd_valid_d;
    logic [SYS_ARR_COLS-1:0]     clear_d, rd_en_d, wr_en_d;
    logic [AW*SYS_ARR_COLS-1:0]  rd_addr_d, wr_addr_d;
    logic [AW:0]                 wsum, rsum;
    int                          tc;

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        base_d  = base_q;
        n_d     = n_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d = base_addr;
                    n_d    = (num_rows > NW'(MAX_OUT_ROWS)) ? NW'(MAX_OUT_ROWS) : num_rows;
                    t_d    = '0;
                    case (op)
                        2'b00:   state_d = S_CLEAR;
                        2'b01:   state_d = (n_d == '0) ? S_FIN : S_WRITE;
                        2'b10:   state_d = (n_d == '0) ? S_FIN : S_READ;
                        default: state_d = S_FIN;
                    endcase
                end
            end
            S_CLEAR: state_d = S_FIN;
            S_WRITE: begin
                // last column finishes SYS_ARR_COLS-1 cycles after column 0
                if (t_q == TW'(n_q) + TW'(SYS_ARR_COLS - 2)) state_d = S_FIN;
                else t_d = t_q + 1'b1;
            end
            S_READ: begin
                if (t_q == TW'(n_q) - 1'b1) state_d = S_FIN;
                else t_d = t_q + 1'b1;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from next-state so they line up with state_q.
    always_comb begin
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_FIN);
        rd_valid_d = rd_en[0];
        clear_d    = {SYS_ARR_COLS{state_d == S_CLEAR}};
        rd_en_d    = {SYS_ARR_COLS{state_d == S_READ}};
        wr_en_d    = '0;
        wr_addr_d  = '0;
        wsum       = '0;
        tc         = 0;
        for (int c = 0; c < SYS_ARR_COLS; c++) begin
            tc   = int'(t_d) - c;
            wsum = {1'b0, base_d} + (AW+1)'(tc);
            if (wsum >= (AW+1)'(NUM_ACCUM_ROWS)) wsum = wsum - (AW+1)'(NUM_ACCUM_ROWS);
            if (state_d == S_WRITE && tc >= 0 && tc < int'(n_d)) begin
                wr_en_d[c]             = 1'b1;
                wr_addr_d[AW*c +: AW]  = wsum[AW-1:0];
            end
        end
        rsum = {1'b0, base_d} + (AW+1)'(t_d);
        if (rsum >= (AW+1)'(NUM_ACCUM_ROWS)) rsum = rsum - (AW+1)'(NUM_ACCUM_ROWS);
        rd_addr_d = (state_d == S_READ) ? {SYS_ARR_COLS{rsum[AW-1:0]}} : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            t_q      <= '0;
            base_q   <= '0;
            n_q      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_valid <= 1'b0;
            clear    <= '0;
            rd_en    <= '0;
            wr_en    <= '0;
            rd_addr  <= '0;
            wr_addr  <= '0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            base_q   <= base_d;
            n_q      <= n_d;
            busy     <= busy_d;
            done     <= done_d;
            rd_valid <= rd_valid_d;
            clear    <= clear_d;
            rd_en    <= rd_en_d;
            wr_en    <= wr_en_d;
            rd_addr  <= rd_addr_d;
            wr_addr  <= wr_addr_d;
        end
    end

`ifdef ACCUM_CTRL_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_busy_cycles <= '0;
            perf_cmds        <= '0;
        end else begin
            if (busy && perf_busy_cycles != '1) perf_busy_cycles <= perf_busy_cycles + 1'b1;
            if (state_q == S_IDLE && start)     perf_cmds <= perf_cmds + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_accum_table_ctrl.sv
// tb/tb_accum_table_ctrl.sv - scoreboard bench for accum_table_ctrl (4 columns, 16 table rows)
module tb_accum_table_ctrl;

    localparam int C = 4;

    logic        clk, reset_n, start;
    logic [1:0]  op;
    logic [3:0]  base_addr, num_rows;
    logic        busy, done, rd_valid;
    logic [3:0]  clear, rd_en, wr_en;
    logic [15:0] rd_addr, wr_addr;
`ifdef ACCUM_CTRL_PERF_EN
    logic [31:0] perf_busy_cycles;
    logic [15:0] perf_cmds;
    logic [15:0] pc_before;
`endif

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        rd_valid;
        logic [3:0]  clear;
        logic [3:0]  rd_en;
        logic [3:0]  wr_en;
        logic [15:0] rd_addr;
        logic [15:0] wr_addr;
    } snap_t;

    snap_t sb[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    accum_table_ctrl #(
        .MAX_OUT_ROWS(8),
        .MAX_OUT_COLS(8),
        .SYS_ARR_ROWS(4),
        .SYS_ARR_COLS(C)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .op(op),
        .base_addr(base_addr),
        .num_rows(num_rows),
        .busy(busy),
        .done(done),
        .rd_valid(rd_valid),
        .clear(clear),
        .rd_en(rd_en),
        .wr_en(wr_en),
        .rd_addr(rd_addr),
        .wr_addr(wr_addr)
`ifdef ACCUM_CTRL_PERF_EN
        ,
        .perf_busy_cycles(perf_busy_cycles),
        .perf_cmds(perf_cmds)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic chk_snap(input string tag, input snap_t e);
        chk({tag, ".busy"},     32'(busy),     32'(e.busy));
        chk({tag, ".done"},     32'(done),     32'(e.done));
        chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(e.rd_valid));
        chk({tag, ".clear"},    32'(clear),    32'(e.clear));
        chk({tag, ".rd_en"},    32'(rd_en),    32'(e.rd_en));
        chk({tag, ".wr_en"},    32'(wr_en),    32'(e.wr_en));
        chk({tag, ".rd_addr"},  32'(rd_addr),  32'(e.rd_addr));
        chk({tag, ".wr_addr"},  32'(wr_addr),  32'(e.wr_addr));
    endtask

    task automatic push_idle(input int cnt);
        for (int i = 0; i < cnt; i++) sb.push_back('0);
    endtask

    // Expected per-cycle outputs starting the cycle after the accepting edge.
    task automatic expect_cmd(input logic [1:0] cop, input int base, input int nr);
        int    n;
        snap_t s;
        n = (nr > 8) ? 8 : nr;
        if (cop == 2'b00) begin
            s = '0; s.busy = 1'b1; s.clear = 4'hF;
            sb.push_back(s);
        end else if (cop == 2'b01 && n > 0) begin
            for (int t = 0; t < n + C - 1; t++) begin
                s = '0; s.busy = 1'b1;
                for (int c = 0; c < C; c++) begin
                    if (t >= c && t < c + n) begin
                        s.wr_en[c] = 1'b1;
                        s.wr_addr[4*c +: 4] = 4'((base + t - c) % 16);
                    end
                end
                sb.push_back(s);
            end
        end else if (cop == 2'b10 && n > 0) begin
            for (int t = 0; t < n; t++) begin
                s = '0; s.busy = 1'b1; s.rd_en = 4'hF; s.rd_valid = (t > 0);
                for (int c = 0; c < C; c++) s.rd_addr[4*c +: 4] = 4'((base + t) % 16);
                sb.push_back(s);
            end
        end
        s = '0; s.busy = 1'b1; s.done = 1'b1; s.rd_valid = (cop == 2'b10 && n > 0);
        sb.push_back(s);
        push_idle(2);
    endtask

    task automatic issue(input logic [1:0] cop, input int base, input int nr, input bit hold);
        op = cop; base_addr = 4'(base); num_rows = 4'(nr); start = 1'b1;
        expect_cmd(cop, base, nr);
        @(negedge clk);
        if (hold) begin
            op = 2'b10; base_addr = 4'd9; num_rows = 4'd2;
        end else begin
            start = 1'b0;
        end
    endtask

    task automatic drain(input string tag, input int maxn, input bit hold);
        snap_t e;
        int    k = 0;
        while (sb.size() > 0 && k < maxn) begin
            e = sb.pop_front();
            chk_snap($sformatf("%s[%0d]", tag, k), e);
            if (hold && !e.busy) start = 1'b0;
            k++;
            @(negedge clk);
        end
    endtask

    initial begin
        reset_n = 1'b1; start = 1'b0; op = 2'b00; base_addr = '0; num_rows = '0;
        #1 reset_n = 1'b0;
        #1 chk_snap("reset", '0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk_snap("post_reset_idle", '0);
`ifdef ACCUM_CTRL_PERF_EN
        chk("perf_cmds_reset", 32'(perf_cmds), 32'd0);
`endif

        issue(2'b00, 0, 0, 1'b0);  drain("clear", 100, 1'b0);
        issue(2'b01, 2, 3, 1'b0);  drain("wr_b2_n3", 100, 1'b0);
        issue(2'b01, 14, 4, 1'b0); drain("wr_b14_n4", 100, 1'b0);
        issue(2'b10, 5, 2, 1'b0);  drain("rd_b5_n2", 100, 1'b0);
        issue(2'b01, 3, 0, 1'b0);  drain("wr_n0", 100, 1'b0);
        issue(2'b10, 7, 0, 1'b0);  drain("rd_n0", 100, 1'b0);
        issue(2'b01, 0, 9, 1'b0);  drain("wr_clamp9", 100, 1'b0);
        issue(2'b10, 12, 9, 1'b0); drain("rd_clamp9_wrap", 100, 1'b0);
        issue(2'b11, 4, 3, 1'b0);  drain("op_rsvd", 100, 1'b0);

`ifdef ACCUM_CTRL_PERF_EN
        pc_before = perf_cmds;
`endif
        issue(2'b01, 2, 3, 1'b1);  drain("start_while_busy", 100, 1'b1);
`ifdef ACCUM_CTRL_PERF_EN
        chk("perf_cmds_busy_start", 32'(perf_cmds), 32'(pc_before) + 32'd1);
`endif

        issue(2'b01, 2, 3, 1'b0);
        drain("rst_wr", 2, 1'b0);
        chk("rst_wr.t2.wr_en", 32'(wr_en), 32'h7);
        chk("rst_wr.t2.wr_addr", 32'(wr_addr), 32'h0234);
        sb.delete();
        #1 reset_n = 1'b0;
        #1 chk_snap("async_reset", '0);
        @(negedge clk);
        reset_n = 1'b1;
        push_idle(3);
        drain("after_reset", 100, 1'b0);
`ifdef ACCUM_CTRL_PERF_EN
        chk("perf_cmds_after_reset", 32'(perf_cmds), 32'd0);
`endif

        issue(2'b00, 0, 0, 1'b0);  drain("recover_clear", 100, 1'b0);
        issue(2'b10, 15, 3, 1'b0); drain("rd_wrap", 100, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
